soc1_ram_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the single-port on-chip RAM (5120 × 32-bit words, byte-enabled, read data one cycle after the address is clocked) between two masters, e.g. the CPU data master and a DMA engine. It sits between the masters and the RAM in the SoC1 interconnect. It grants at most one transfer per cycle with round-robin fairness and routes the one-cycle-late read data back to the issuing master. Out-of-range accesses are filtered and counted.

---
 rtl/soc1_mem_pkg.sv | 31 +++
 rtl/soc1_rr_arb2.sv | 47 ++++
 rtl/soc1_ram_arbiter.sv | 136 +++++++++++++
 tb/tb_soc1_ram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc1_mem_pkg.sv
// Shared constants, port identifier and request bundle for the SoC1 on-chip
// RAM and the masters that share it.
package soc1_mem_pkg;

    localparam int RAM_DEPTH = 5120;
    localparam int RAM_AW    = 13;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam int ERR_W     = 8;

    // Identifies one of the two masters sharing a slave.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // One master's request as seen by the interconnect.
    typedef struct packed {
        logic [RAM_AW-1:0] address;
        logic              read;
        logic              write;
        logic [BE_W-1:0]   byteenable;
        logic [DATA_W-1:0] writedata;
    } avmm_req_t;

    // True when a word address falls inside the physical RAM.
    function automatic logic in_range(input logic [RAM_AW-1:0] addr);
        return (addr < RAM_AW'(RAM_DEPTH));
    endfunction

endpackage

// File: rtl/soc1_rr_arb2.sv
// Two-way round-robin arbiter. Grants combinationally; on a tie the port that
// did not win last time is chosen. Reusable in front of any shared slave.
module soc1_rr_arb2
    import soc1_mem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    port_e last_q;
    port_e last_d;

    // Pick a winner: a lone requester always wins, a tie goes to the other port.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (req0_i && req1_i) begin
            if (last_q == PORT1) gnt0_o = 1'b1;
            else                 gnt1_o = 1'b1;
        end else begin
            gnt0_o = req0_i;
            gnt1_o = req1_i;
        end
    end

    // Remember who won; hold through idle cycles.
    always_comb begin
        last_d = last_q;
        if (gnt0_o)      last_d = PORT0;
        else if (gnt1_o) last_d = PORT1;
    end

    // Last-grant register; reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples its pre-edge inputs regardless of block evaluation order.
        if (!reset_n) last_q <= PORT1;
        else          last_q <= last_d;
    end

endmodule

// File: rtl/soc1_ram_arbiter.sv
// Shares the single-port on-chip RAM between two Avalon-MM masters: one
// transfer per cycle, round-robin on contention, read data routed back to the
// issuing master one cycle later, out-of-range accesses dropped and counted.
module soc1_ram_arbiter
    import soc1_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,

    input  logic [RAM_AW-1:0] av0_address,
    input  logic              av0_read,
    input  logic              av0_write,
    input  logic [BE_W-1:0]   av0_byteenable,
    input  logic [DATA_W-1:0] av0_writedata,
    output logic              av0_waitrequest,
    output logic [DATA_W-1:0] av0_readdata,
    output logic              av0_readdatavalid,

    input  logic [RAM_AW-1:0] av1_address,
    input  logic              av1_read,
    input  logic              av1_write,
    input  logic [BE_W-1:0]   av1_byteenable,
    input  logic [DATA_W-1:0] av1_writedata,
    output logic              av1_waitrequest,
    output logic [DATA_W-1:0] av1_readdata,
    output logic              av1_readdatavalid,

    output logic [RAM_AW-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,

    output logic [ERR_W-1:0]  err_count
);

    avmm_req_t        req0;
    avmm_req_t        req1;
    avmm_req_t        sel_req;
    logic             want0;
    logic             want1;
    logic             arb_gnt0;
    logic             arb_gnt1;
    logic             gnt0;
    logic             gnt1;
    logic             granted;
    logic             sel_in_range;
    logic             issue_read;
    logic             issue_oor;

    logic             rd_valid_q, rd_valid_d;
    logic             rd_oor_q,   rd_oor_d;
    port_e            rd_owner_q, rd_owner_d;
    logic [ERR_W-1:0] err_q,      err_d;
    logic [DATA_W-1:0] ret_data;

    assign req0 = '{address: av0_address, read: av0_read, write: av0_write,
                    byteenable: av0_byteenable, writedata: av0_writedata};
    assign req1 = '{address: av1_address, read: av1_read, write: av1_write,
                    byteenable: av1_byteenable, writedata: av1_writedata};

    assign want0 = av0_read | av0_write;
    assign want1 = av1_read | av1_write;

    soc1_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req0_i  (want0),
        .req1_i  (want1),
        .gnt0_o  (arb_gnt0),
        .gnt1_o  (arb_gnt1)
    );

    // No transfer is accepted while reset is held.
    assign gnt0 = arb_gnt0 & reset_n;
    assign gnt1 = arb_gnt1 & reset_n;

    assign av0_waitrequest = ~reset_n | (want0 & ~gnt0);
    assign av1_waitrequest = ~reset_n | (want1 & ~gnt1);

    // Route the winner to the RAM (port 0 when idle) and classify the transfer.
    always_comb begin
        sel_req      = gnt1 ? req1 : req0;
        granted      = gnt0 | gnt1;
        sel_in_range = in_range(sel_req.address);
        // A simultaneous read+write is treated purely as a write.
        issue_read   = granted & sel_req.read & ~sel_req.write;
        issue_oor    = granted & ~sel_in_range;
    end

    assign ram_address    = sel_req.address;
    assign ram_byteenable = sel_req.byteenable;
    assign ram_writedata  = sel_req.writedata;
    assign ram_chipselect = granted & sel_in_range;
    assign ram_write      = granted & sel_in_range & sel_req.write;
    assign ram_clken      = 1'b1;

    // Next state of the read-return tracker and the saturating error counter.
    always_comb begin
        rd_valid_d = issue_read;
        rd_oor_d   = issue_read & ~sel_in_range;
        rd_owner_d = rd_owner_q;
        if (granted) rd_owner_d = gnt1 ? PORT1 : PORT0;

        err_d = err_q;
        if (issue_oor && (err_q != {ERR_W{1'b1}})) err_d = err_q + ERR_W'(1);
    end

    // Read-return pipeline register and error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
            rd_owner_q <= PORT0;
            err_q      <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_oor_q   <= rd_oor_d;
            rd_owner_q <= rd_owner_d;
            err_q      <= err_d;
        end
    end

    // Out-of-range reads return zero instead of whatever the RAM last drove.
    assign ret_data = rd_oor_q ? '0 : ram_readdata;

    assign av0_readdata      = ret_data;
    assign av1_readdata      = ret_data;
    assign av0_readdatavalid = rd_valid_q & (rd_owner_q == PORT0);
    assign av1_readdatavalid = rd_valid_q & (rd_owner_q == PORT1);

    assign err_count = err_q;

endmodule

// File: tb/tb_soc1_ram_arbiter.sv
// Bench for soc1_ram_arbiter: a behavioural RAM, a directed vector table,
// hand-written reset/saturation sequences and randomized traffic checked
// against a transaction-level reference model.
module tb_soc1_ram_arbiter;
    import soc1_mem_pkg::*;

    typedef struct packed {
        logic        wait0;
        logic        wait1;
        logic        rdv0;
        logic        rdv1;
        logic [31:0] rdata;
        logic        cs;
        logic        we;
        logic [7:0]  err;
    } exp_t;

    typedef struct packed {
        avmm_req_t p0;
        avmm_req_t p1;
        exp_t      e;
    } vec_t;

    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] av0_address, av1_address;
    logic        av0_read, av0_write, av1_read, av1_write;
    logic [3:0]  av0_byteenable, av1_byteenable;
    logic [31:0] av0_writedata, av1_writedata;
    logic        av0_waitrequest, av1_waitrequest;
    logic [31:0] av0_readdata, av1_readdata;
    logic        av0_readdatavalid, av1_readdatavalid;
    logic [12:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata = '0;
    logic [7:0]  err_count;

    int n_vec;
    int n_bad;

    // Behavioural RAM and the model's own view of its contents.
    logic [31:0] mem [0:RAM_DEPTH-1];
    logic [31:0] mm  [0:RAM_DEPTH-1];

    // Reference model state, kept at transaction level.
    int          m_last;
    bit          m_pv;
    int          m_po;
    logic [31:0] m_pd;
    int          m_err;

    vec_t vt [NV];

    always #5 clk = ~clk;

    soc1_ram_arbiter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .av0_address       (av0_address),
        .av0_read          (av0_read),
        .av0_write         (av0_write),
        .av0_byteenable    (av0_byteenable),
        .av0_writedata     (av0_writedata),
        .av0_waitrequest   (av0_waitrequest),
        .av0_readdata      (av0_readdata),
        .av0_readdatavalid (av0_readdatavalid),
        .av1_address       (av1_address),
        .av1_read          (av1_read),
        .av1_write         (av1_write),
        .av1_byteenable    (av1_byteenable),
        .av1_writedata     (av1_writedata),
        .av1_waitrequest   (av1_waitrequest),
        .av1_readdata      (av1_readdata),
        .av1_readdatavalid (av1_readdatavalid),
        .ram_address       (ram_address),
        .ram_byteenable    (ram_byteenable),
        .ram_chipselect    (ram_chipselect),
        .ram_write         (ram_write),
        .ram_writedata     (ram_writedata),
        .ram_clken         (ram_clken),
        .ram_readdata      (ram_readdata),
        .err_count         (err_count)
    );

    // Single-port RAM: byte-enabled write, read data registered one cycle later.
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect && (int'(ram_address) < RAM_DEPTH)) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic avmm_req_t mk(input bit rd, input bit wr, input int addr,
                                     input logic [3:0] be, input logic [31:0] wd);
        avmm_req_t q;
        q.address    = 13'(addr);
        q.read       = rd;
        q.write      = wr;
        q.byteenable = be;
        q.writedata  = wd;
        return q;
    endfunction

    function automatic exp_t ex(input bit w0, input bit w1, input bit v0, input bit v1,
                                input logic [31:0] rd, input bit cs, input bit we,
                                input int err);
        exp_t e;
        e.wait0 = w0; e.wait1 = w1; e.rdv0 = v0; e.rdv1 = v1;
        e.rdata = rd; e.cs = cs; e.we = we; e.err = 8'(err);
        return e;
    endfunction

    function automatic avmm_req_t rnd_req();
        int k = int'($urandom_range(0, 7));
        int s = int'($urandom_range(0, 15));
        int a;
        if (s == 0)      a = int'($urandom_range(RAM_DEPTH - 2, RAM_DEPTH + 1));
        else if (s == 1) a = int'($urandom_range(RAM_DEPTH, 8191));
        else             a = int'($urandom_range(0, 31));
        return mk(k inside {[2:4], 7}, k inside {[5:7]}, a, 4'($urandom_range(0, 15)), $urandom);
    endfunction

    task automatic drive(input avmm_req_t q0, input avmm_req_t q1);
        av0_address = q0.address; av0_read = q0.read; av0_write = q0.write;
        av0_byteenable = q0.byteenable; av0_writedata = q0.writedata;
        av1_address = q1.address; av1_read = q1.read; av1_write = q1.write;
        av1_byteenable = q1.byteenable; av1_writedata = q1.writedata;
    endtask

    task automatic model_reset();
        m_last = 1; m_pv = 0; m_po = 0; m_pd = '0; m_err = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".wait0"}, 32'(av0_waitrequest), 32'd1);
        check({tag, ".wait1"}, 32'(av1_waitrequest), 32'd1);
        check({tag, ".rdv0"},  32'(av0_readdatavalid), 32'd0);
        check({tag, ".rdv1"},  32'(av1_readdatavalid), 32'd0);
        check({tag, ".cs"},    32'(ram_chipselect), 32'd0);
        check({tag, ".we"},    32'(ram_write), 32'd0);
        check({tag, ".err"},   32'(err_count), 32'd0);
        check({tag, ".clken"}, 32'(ram_clken), 32'd1);
    endtask

    // One bus cycle: drive, compare mid-cycle, advance the model, cross the edge.
    task automatic step(input avmm_req_t q0, input avmm_req_t q1, input bit tbl,
                        input exp_t te, input string tag);
        exp_t      e;
        avmm_req_t w;
        bit        rq0, rq1;
        int        win;
        drive(q0, q1);
        rq0 = q0.read | q0.write;
        rq1 = q1.read | q1.write;
        if (rq0 && rq1) win = 1 - m_last;
        else if (rq0)   win = 0;
        else if (rq1)   win = 1;
        else            win = -1;
        w = (win == 1) ? q1 : q0;
        e.wait0 = rq0 && (win != 0);
        e.wait1 = rq1 && (win != 1);
        e.rdv0  = m_pv && (m_po == 0);
        e.rdv1  = m_pv && (m_po == 1);
        e.rdata = m_pd;
        e.cs    = (win >= 0) && (int'(w.address) < RAM_DEPTH);
        e.we    = e.cs && w.write;
        e.err   = 8'(m_err);
        if (tbl) e = te;

        @(negedge clk);
        check({tag, ".wait0"}, 32'(av0_waitrequest), 32'(e.wait0));
        check({tag, ".wait1"}, 32'(av1_waitrequest), 32'(e.wait1));
        check({tag, ".rdv0"},  32'(av0_readdatavalid), 32'(e.rdv0));
        check({tag, ".rdv1"},  32'(av1_readdatavalid), 32'(e.rdv1));
        check({tag, ".cs"},    32'(ram_chipselect), 32'(e.cs));
        check({tag, ".we"},    32'(ram_write), 32'(e.we));
        check({tag, ".err"},   32'(err_count), 32'(e.err));
        if (e.rdv0 || e.rdv1) begin
            check({tag, ".rdata0"}, av0_readdata, e.rdata);
            check({tag, ".rdata1"}, av1_readdata, e.rdata);
        end
        if (e.cs) check({tag, ".addr"}, 32'(ram_address), 32'(w.address));

        if (win >= 0) begin
            if (w.write && (int'(w.address) < RAM_DEPTH))
                for (int b = 0; b < 4; b++)
                    if (w.byteenable[b]) mm[w.address][8*b +: 8] = w.writedata[8*b +: 8];
            m_pv = w.read && !w.write;
            m_po = win;
            m_pd = (int'(w.address) < RAM_DEPTH) ? mm[w.address] : 32'h0;
            if ((int'(w.address) >= RAM_DEPTH) && (m_err < 255)) m_err++;
            m_last = win;
        end else begin
            m_pv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        avmm_req_t idle;
        avmm_req_t rq;
        exp_t      none;
        n_vec = 0;
        n_bad = 0;
        idle  = mk(0, 0, 0, 4'h0, 32'h0);
        none  = '0;

        for (int i = 0; i < RAM_DEPTH; i++) begin
            mem[i] = '0;
            mm[i]  = '0;
        end
        mem[16'h10] = 32'hCAFEF00D; mm[16'h10] = 32'hCAFEF00D;
        mem[16'h20] = 32'h12345678; mm[16'h20] = 32'h12345678;

        // Directed vectors: {port0 request, port1 request, expected outputs}.
        vt[0]  = '{mk(1,0,'h10,0,0), mk(1,0,'h20,0,0), ex(0,1,0,0,0,1,0,0)};
        vt[1]  = '{mk(1,0,'h10,0,0), mk(1,0,'h20,0,0), ex(1,0,1,0,32'hCAFEF00D,1,0,0)};
        vt[2]  = '{mk(1,0,'h10,0,0), mk(1,0,'h20,0,0), ex(0,1,0,1,32'h12345678,1,0,0)};
        vt[3]  = '{mk(1,0,'h10,0,0), mk(1,0,'h20,0,0), ex(1,0,1,0,32'hCAFEF00D,1,0,0)};
        vt[4]  = '{mk(1,0,'h10,0,0), mk(1,0,'h20,0,0), ex(0,1,0,1,32'h12345678,1,0,0)};
        vt[5]  = '{mk(1,0,'h10,0,0), mk(1,0,'h20,0,0), ex(1,0,1,0,32'hCAFEF00D,1,0,0)};
        vt[6]  = '{idle,                idle,                ex(0,0,0,1,32'h12345678,0,0,0)};
        vt[7]  = '{mk(1,0,'h10,0,0), idle,                ex(0,0,0,0,0,1,0,0)};
        vt[8]  = '{idle,                idle,                ex(0,0,1,0,32'hCAFEF00D,0,0,0)};
        vt[9]  = '{idle, mk(0,1,5,4'b0101,32'h11223344),  ex(0,0,0,0,0,1,1,0)};
        vt[10] = '{idle, mk(1,0,5,0,0),                    ex(0,0,0,0,0,1,0,0)};
        vt[11] = '{idle, mk(1,1,7,4'hF,32'hA5A5A5A5),     ex(0,0,0,1,32'h00220044,1,1,0)};
        vt[12] = '{idle, mk(1,0,7,0,0),                    ex(0,0,0,0,0,1,0,0)};
        vt[13] = '{idle,                idle,                ex(0,0,0,1,32'hA5A5A5A5,0,0,0)};
        vt[14] = '{mk(0,1,5120,4'hF,32'hDEADBEEF), idle,  ex(0,0,0,0,0,0,0,0)};
        vt[15] = '{mk(1,0,8191,0,0), idle,                 ex(0,0,0,0,0,0,0,1)};
        vt[16] = '{idle,                idle,                ex(0,0,1,0,32'h00000000,0,0,2)};
        vt[17] = '{mk(1,0,1024,0,0), idle,                 ex(0,0,0,0,0,1,0,2)};
        vt[18] = '{idle,                idle,                ex(0,0,1,0,32'h00000000,0,0,2)};

        // Reset with a request pending on port 0: nothing may reach the RAM.
        reset_n = 1'b0;
        drive(mk(1, 0, 'h10, 0, 0), idle);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        drive(idle, idle);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++)
            step(vt[i].p0, vt[i].p1, 1'b1, vt[i].e, $sformatf("vec%0d", i));

        // Push the error counter into saturation.
        for (int i = 0; i < 300; i++) begin
            rq = mk($urandom_range(0, 1) == 1, 1'b0, int'($urandom_range(RAM_DEPTH, 8191)),
                    4'hF, $urandom);
            rq.write = ~rq.read;
            if ($urandom_range(0, 1) == 1) step(idle, rq, 1'b0, none, "oor");
            else                           step(rq, idle, 1'b0, none, "oor");
        end
        step(idle, idle, 1'b0, none, "oor_tail");
        check("err_sat", 32'(err_count), 32'd255);

        // Reset dropped the cycle after a read issue: the data never returns.
        step(mk(1, 0, 'h10, 0, 0), idle, 1'b0, none, "pre_rst");
        reset_n = 1'b0;
        drive(mk(1, 0, 'h10, 0, 0), idle);
        #1;
        check_reset("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset("midrst_hold");
        drive(idle, idle);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(mk(1, 0, 'h20, 0, 0), mk(1, 0, 'h10, 0, 0), 1'b0, none, "post_rst");
        step(idle, idle, 1'b0, none, "post_rst_ret");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++)
            step(rnd_req(), rnd_req(), 1'b0, none, "rnd");
        step(idle, idle, 1'b0, none, "rnd_tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
